// File: rtl/dma_write_master.sv
// AXI4 write-side DMA master: drains a FWFT FIFO into destination memory as INCR bursts,
// one burst in flight, split at the burst-length limit and at 4 KB boundaries.
module dma_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
    input  logic [31:0]                     i_total_len,
    output logic                            o_busy,
    output logic                            o_write_done,
    output logic                            o_resp_err,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_fifo_data,
    input  logic                            i_fifo_empty,
    output logic                            o_fifo_pop,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    localparam logic [31:0] MAX_LEN = 32'(C_MAX_BURST_LEN);

    state_t                          state;
    state_t                          state_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
    logic [31:0]                     rem;
    logic [8:0]                      blen;
    logic [8:0]                      beat;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]                      awlen_q;
    logic                            resp_err;

    logic                            busy;
    logic                            done;
    logic                            awvalid;
    logic                            wvalid;
    logic                            wlast;
    logic                            bready;
    logic                            w_fire;

    logic [31:0]                     room_words;
    logic [31:0]                     cap_words;
    logic [8:0]                      blen_calc;

    // Burst size is the smallest of words left, the burst limit and words to the next 4 KB page.
    always_comb begin
        room_words = (32'd4096 - {20'd0, addr[11:0]}) >> 2;
        cap_words  = (rem < MAX_LEN) ? rem : MAX_LEN;
        if (room_words < cap_words) begin
            cap_words = room_words;
        end
        blen_calc = 9'(cap_words);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy       = 1'b1;
                state_next = (rem == 32'd0) ? S_DONE : S_AW;
            end
            S_AW: begin
                busy    = 1'b1;
                awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_next = S_W;
                end
            end
            S_W: begin
                busy   = 1'b1;
                wvalid = !i_fifo_empty;
                wlast  = (beat == {1'b0, awlen_q});
                if (wvalid && m_axi_wready && wlast) begin
                    state_next = S_B;
                end
            end
            S_B: begin
                busy   = 1'b1;
                bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_next = S_CALC;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign w_fire = wvalid & m_axi_wready;

    // The address/remaining pair only advances once the slave has acknowledged the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            rem      <= '0;
            blen     <= '0;
            beat     <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        addr     <= i_dst_addr & ~C_M_AXI_ADDR_WIDTH'(3);
                        rem      <= i_total_len >> 2;
                        resp_err <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (rem != 32'd0) begin
                        blen     <= blen_calc;
                        awaddr_q <= addr;
                        awlen_q  <= 8'(blen_calc - 9'd1);
                        beat     <= '0;
                    end
                end
                S_W: begin
                    if (w_fire) begin
                        beat <= beat + 9'd1;
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) begin
                            resp_err <= 1'b1;
                        end
                        addr <= addr + (C_M_AXI_ADDR_WIDTH'(blen) << 2);
                        rem  <= rem - 32'(blen);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy        = busy;
    assign o_write_done  = done;
    assign o_resp_err    = resp_err;
    assign o_fifo_pop    = w_fire;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid;
    assign m_axi_wdata   = i_fifo_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast;
    assign m_axi_wvalid  = wvalid;
    assign m_axi_bready  = bready;

endmodule

// File: tb/tb_dma_write_master.sv
// Randomized bench for dma_write_master: FIFO/slave models plus a burst-list and data-order
// reference computed directly from the transfer parameters.
module tb_dma_write_master;

    localparam int MAX_BURST = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [31:0] i_dst_addr;
    logic [31:0] i_total_len;
    logic        o_busy;
    logic        o_write_done;
    logic        o_resp_err;
    logic [31:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_pop;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    dma_write_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_MAX_BURST_LEN   (MAX_BURST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_dst_addr   (i_dst_addr),
        .i_total_len  (i_total_len),
        .o_busy       (o_busy),
        .o_write_done (o_write_done),
        .o_resp_err   (o_resp_err),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_pop   (o_fifo_pop),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awlen  (m_axi_awlen),
        .m_axi_awsize (m_axi_awsize),
        .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wlast  (m_axi_wlast),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t      exp_bursts[$];
    logic [31:0] exp_data[$];
    logic [31:0] fifo_q[$];
    logic [1:0]  resp_plan[$];

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_bursts_exp;
    int n_words_exp;
    logic exp_err;

    int aw_seen, w_seen, b_seen, pop_seen, done_count, awv_cycles, tb_beat;
    logic [7:0] cur_awlen;
    bit   b_pending, pop_flag, presented, keep, gate;
    bit   prev_aw_stall, prev_w_stall, prev_done;
    logic [31:0] held_awaddr;
    logic done_err, done_busy;

    bit rand_wready, fifo_toggle;
    int aw_delay, aw_cnt, cyc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},    32'(o_busy),        32'd0);
        checkOutput({tag, "_done"},    32'(o_write_done),  32'd0);
        checkOutput({tag, "_resperr"}, 32'(o_resp_err),    32'd0);
        checkOutput({tag, "_pop"},     32'(o_fifo_pop),    32'd0);
        checkOutput({tag, "_awvalid"}, 32'(m_axi_awvalid), 32'd0);
        checkOutput({tag, "_wvalid"},  32'(m_axi_wvalid),  32'd0);
        checkOutput({tag, "_wlast"},   32'(m_axi_wlast),   32'd0);
        checkOutput({tag, "_bready"},  32'(m_axi_bready),  32'd0);
        checkOutput({tag, "_awaddr"},  m_axi_awaddr,       32'd0);
        checkOutput({tag, "_awlen"},   32'(m_axi_awlen),   32'd0);
    endtask

    // Monitor: handshakes are judged at the falling edge, where they are stable for the next rise.
    always @(negedge clk) begin
        burst_t eb;
        if (reset) begin
            prev_aw_stall = 1'b0;
            prev_w_stall  = 1'b0;
            prev_done     = 1'b0;
        end else begin
            checkOutput("aw_w_overlap", 32'(m_axi_awvalid & m_axi_wvalid), 32'd0);
            if (prev_aw_stall) begin
                checkOutput("awvalid_hold", 32'(m_axi_awvalid), 32'd1);
                checkOutput("awaddr_hold", m_axi_awaddr, held_awaddr);
            end
            if (prev_w_stall) checkOutput("wvalid_hold", 32'(m_axi_wvalid), 32'd1);
            if (prev_done) checkOutput("done_width", 32'(o_write_done), 32'd0);
            if (m_axi_awvalid) awv_cycles++;
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_bursts.size() > 0) begin
                    eb = exp_bursts.pop_front();
                    checkOutput("awaddr", m_axi_awaddr, eb.addr);
                    checkOutput("awlen", 32'(m_axi_awlen), 32'(eb.len));
                    cur_awlen = eb.len;
                end else begin
                    checkOutput("aw_count", 32'(aw_seen + 1), 32'(n_bursts_exp));
                end
                checkOutput("awsize", 32'(m_axi_awsize), 32'd2);
                checkOutput("awburst", 32'(m_axi_awburst), 32'd1);
                tb_beat = 0;
                aw_seen++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_data.size() > 0) checkOutput("wdata", m_axi_wdata, exp_data.pop_front());
                else checkOutput("w_count", 32'(w_seen + 1), 32'(n_words_exp));
                checkOutput("wlast", 32'(m_axi_wlast), 32'(tb_beat == int'(cur_awlen)));
                checkOutput("wstrb", 32'(m_axi_wstrb), 32'hF);
                if (m_axi_wlast) b_pending = 1'b1;
                tb_beat++;
                w_seen++;
            end
            if (o_fifo_pop) begin
                pop_seen++;
                pop_flag = 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                checkOutput("beats_per_burst", 32'(tb_beat), 32'(int'(cur_awlen) + 1));
                b_seen++;
                b_pending = 1'b0;
            end
            if (o_write_done) begin
                done_count++;
                done_err  = o_resp_err;
                done_busy = o_busy;
            end
            prev_aw_stall = m_axi_awvalid && !m_axi_awready;
            held_awaddr   = m_axi_awaddr;
            prev_w_stall  = m_axi_wvalid && !m_axi_wready;
            prev_done     = o_write_done;
        end
    end

    // FWFT FIFO and slave: a presented word stays valid until it is popped.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            i_fifo_empty  = 1'b1;
            i_fifo_data   = 32'd0;
            aw_cnt        = 0;
            pop_flag      = 1'b0;
            b_pending     = 1'b0;
            presented     = 1'b0;
        end else begin
            if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
            keep     = presented && !pop_flag;
            pop_flag = 1'b0;
            cyc++;
            gate         = fifo_toggle && ((cyc / 3) % 2 == 1);
            i_fifo_empty = (fifo_q.size() == 0) || (gate && !keep);
            i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
            presented    = !i_fifo_empty;
            if (m_axi_awvalid) begin
                m_axi_awready = (aw_cnt >= aw_delay);
                aw_cnt++;
            end else begin
                m_axi_awready = 1'b0;
                aw_cnt        = 0;
            end
            m_axi_wready = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_pending) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_seen < resp_plan.size()) ? resp_plan[b_seen] : 2'b00;
            end else begin
                m_axi_bvalid = 1'b0;
                m_axi_bresp  = 2'b00;
            end
        end
    end

    // Reference: walk the transfer in whole bursts, each capped by length, limit and 4 KB page.
    task automatic startTransfer(input logic [31:0] addr, input logic [31:0] len, input bit rw,
                                 input int ad, input bit ft, input int err_mode);
        logic [31:0] a;
        int r, b, room;
        logic [1:0] rsp;
        logic [31:0] word;
        exp_bursts.delete();
        exp_data.delete();
        fifo_q.delete();
        resp_plan.delete();
        exp_err = 1'b0;
        a = addr & 32'hFFFF_FFFC;
        r = int'(len / 4);
        n_words_exp = r;
        while (r > 0) begin
            b = (r < MAX_BURST) ? r : MAX_BURST;
            room = (4096 - int'(a % 32'd4096)) / 4;
            if (b > room) b = room;
            exp_bursts.push_back({a, 8'(b - 1)});
            if (err_mode == 1) rsp = (resp_plan.size() == 0) ? 2'b10 : 2'b00;
            else if (err_mode == 2 && $urandom_range(0, 3) == 0) rsp = 2'($urandom_range(1, 3));
            else rsp = 2'b00;
            resp_plan.push_back(rsp);
            if (rsp != 2'b00) exp_err = 1'b1;
            a = a + 32'(b * 4);
            r = r - b;
        end
        n_bursts_exp = exp_bursts.size();
        for (int i = 0; i < n_words_exp; i++) begin
            word = $urandom;
            fifo_q.push_back(word);
            exp_data.push_back(word);
        end
        rand_wready = rw;
        aw_delay    = ad;
        fifo_toggle = ft;
        aw_seen = 0; w_seen = 0; b_seen = 0; pop_seen = 0;
        done_count = 0; awv_cycles = 0; tb_beat = 0;
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_dst_addr  = addr;
        i_total_len = len;
        @(posedge clk); #1;
        i_start = 1'b0;
        checkOutput("busy_after_start", 32'(o_busy), 32'd1);
        checkOutput("resp_err_cleared", 32'(o_resp_err), 32'd0);
        if (n_words_exp == 0) begin
            @(posedge clk); #1;
            checkOutput("zero_len_done", 32'(o_write_done), 32'd1);
        end
    endtask

    task automatic finishTransfer();
        int budget;
        int i;
        budget = 40 * n_words_exp + 100;
        i = 0;
        while (done_count == 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (done_count == 0) begin
            checkOutput("done_timeout", 32'(done_count), 32'd1);
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            return;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", 32'(done_count), 32'd1);
        checkOutput("aw_total", 32'(aw_seen), 32'(n_bursts_exp));
        checkOutput("w_total", 32'(w_seen), 32'(n_words_exp));
        checkOutput("pop_total", 32'(pop_seen), 32'(n_words_exp));
        checkOutput("b_total", 32'(b_seen), 32'(n_bursts_exp));
        checkOutput("resp_err_at_done", 32'(done_err), 32'(exp_err));
        checkOutput("busy_at_done", 32'(done_busy), 32'd0);
        checkOutput("resp_err_sticky", 32'(o_resp_err), 32'(exp_err));
        checkOutput("data_left", 32'(exp_data.size()), 32'd0);
        if (n_words_exp == 0) checkOutput("awvalid_zero_len", 32'(awv_cycles), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len, input bit rw,
                                 input int ad, input bit ft, input int err_mode);
        startTransfer(addr, len, rw, ad, ft, err_mode);
        finishTransfer();
    endtask

    initial begin
        int dc;
        logic [31:0] ra;
        reset = 1'b1; i_start = 1'b0; i_dst_addr = 32'd0; i_total_len = 32'd0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        i_fifo_empty = 1'b1; i_fifo_data = 32'd0;
        rand_wready = 1'b0; fifo_toggle = 1'b0; aw_delay = 0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;

        applyStimulus(32'h0000_1000, 32'd64,  1'b0, 0, 1'b0, 0);
        applyStimulus(32'h0000_0000, 32'd100, 1'b0, 0, 1'b0, 0);
        applyStimulus(32'h0000_0FF8, 32'd32,  1'b0, 0, 1'b0, 0);
        applyStimulus(32'h0000_2000, 32'd160, 1'b1, 5, 1'b1, 0);
        applyStimulus(32'h0000_3000, 32'd128, 1'b0, 0, 1'b0, 1);
        applyStimulus(32'h0000_4000, 32'd0,   1'b0, 0, 1'b0, 0);

        // Reset while the fifth beat of the first burst is on the bus.
        startTransfer(32'h0000_5000, 32'd256, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 200 && w_seen < 4; i++) @(posedge clk);
        #1;
        checkOutput("reached_beat5", 32'(w_seen), 32'd4);
        reset = 1'b1;
        @(posedge clk); #1;
        checkIdleOutputs("mid_reset");
        dc = done_count;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no_done_after_reset", 32'(done_count), 32'(dc));
        checkOutput("idle_after_reset", 32'(o_busy), 32'd0);

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1) ra = $urandom;
            else ra = 32'($urandom_range(1, 8) * 4096) - 32'($urandom_range(0, 24) * 4);
            applyStimulus(ra, 32'($urandom_range(0, 400)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dma_write_master.md
Name: dma_write_master

Overview:
- Write-side AXI4-Full master of the DMA: downstream consumer of the read-side FIFO.
- Pops words from the FIFO and writes them to destination memory as INCR bursts (AW, then W, then B), one burst outstanding at a time.
- Splits transfers at MAX_BURST_LEN and at 4 KB boundaries.
- Pulses done when the final write response is accepted.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI/FIFO data width; only 32 is supported.
- C_MAX_BURST_LEN, 16, maximum beats per burst, 1..256.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; honoured only in IDLE.
- i_dst_addr  in  32  destination byte address; bits [1:0] forced to 0.
- i_total_len  in  32  byte count; bits [1:0] ignored; words = len>>2.
- o_busy  out  1  high from the cycle after the accepted start until done.
- o_write_done  out  1  one-cycle pulse when the transfer completes.
- o_resp_err  out  1  sticky: any BRESP != OKAY in the current transfer; cleared on the next accepted start.
- i_fifo_data  in  32  FWFT FIFO head word; valid whenever !i_fifo_empty.
- i_fifo_empty  in  1  FIFO empty.
- o_fifo_pop  out  1  equals wvalid & wready.
- m_axi_awaddr  out  32  burst address.
- m_axi_awlen  out  8  beats-1.
- m_axi_awsize  out  3  constant 3'b010.
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address ready.
- m_axi_wdata  out  32  = i_fifo_data.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wlast  out  1  last beat of the burst.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  response valid.
- m_axi_bready  out  1  response ready.

Behaviour:
- Reset: on a clk edge with reset=1, go to IDLE and clear address, remaining count, beat counter and error flag.
- Reset values: o_busy, o_write_done, o_resp_err, o_fifo_pop, awvalid, wvalid, wlast and bready are all 0; awaddr and awlen are 0.
- Reset mid-transfer abandons the transfer immediately; no done pulse is generated.

State machine:
- IDLE: on i_start, latch addr = i_dst_addr & ~3, rem = i_total_len>>2, clear o_resp_err, go to CALC. i_start in any other state is ignored.
- CALC (1 cycle):
  - If rem==0, go to DONE.
  - Otherwise blen = min(rem, C_MAX_BURST_LEN, (4096 - addr[11:0])>>2).
  - Register awaddr=addr, awlen=blen-1, beat=0; go to AW.
- AW: awvalid=1 until awready is sampled high, then go to W. awvalid and awaddr are held stable while waiting.
- W:
  - wvalid = !i_fifo_empty; the FWFT FIFO guarantees wvalid never drops before the handshake.
  - wlast = (beat == awlen).
  - Each wvalid&wready increments beat and pops the FIFO.
  - The handshake with wlast=1 moves to B.
  - An empty FIFO stalls with wvalid=0; no bubble is added beyond what the FIFO causes.
- B:
  - bready=1. On bvalid: set o_resp_err if bresp != 2'b00; addr += blen*4; rem -= blen.
  - Then go to CALC. The next CALC sees rem==0 and moves to DONE.
- DONE: o_write_done=1 for exactly one cycle, o_busy=0, go to IDLE.
- Zero-length transfer: start, then CALC, then DONE. Done pulses 2 cycles after start; no AXI activity.
- Arithmetic: rem and the address adder are 32-bit. addr wrapping past 2^32 wraps modulo 2^32 (no protection).
- AW and W are never concurrent: W starts only after the AW handshake.
- Max throughput: 1 beat/cycle in W.
- Per-burst overhead: CALC + AW handshake + B (at least 3 cycles).

Test Plan:
- Aligned single burst: start, addr 0x1000, len 64, FIFO full, slave always ready -> one AW (0x1000, awlen=15); 16 beats with wlast on beat 16; 16 pops; bready handshake; one done pulse; o_resp_err=0.
- Split by length: addr 0x0, len 100 -> AW 0x0 awlen=15, then AW 0x40 awlen=8; 25 pops total; done after the second B.
- 4 KB split: addr 0x0FF8, len 32 -> AW 0x0FF8 awlen=1, then AW 0x1000 awlen=5; wlast on beats 2 and 6.
- Backpressure: i_fifo_empty toggles every 3 cycles, wready random, awready delayed 5 cycles -> awvalid/awaddr stable until accepted; wvalid never drops before handshake; pops == handshakes; data order preserved.
- Error response: len 128 with BRESP=SLVERR on the first burst only -> o_resp_err=1 through done; transfer still completes; cleared on the next start.
- Zero length / reset: len 0 -> done 2 cycles after start, awvalid never asserted. Separately, reset asserted during beat 5 -> next cycle all outputs 0, state IDLE, no done pulse.
